// File: rtl/hub_linear_fold_ctrl.sv
// Frame sequencer for a folded linear layer: optional weight load, accumulator
// clear, then FOLD parts of SLEN bitstream cycles plus PLAT settle cycles each.
module hub_linear_fold_ctrl #(
   parameter int FOLD = 1,
   parameter int PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
   parameter int SLEN = 1024,
   parameter int PLAT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iStart,
   input  logic            iLoadW,
   output logic            oBusy,
   output logic            oLoad,
   output logic            oClear,
   output logic            oSel,
   output logic [PWID-1:0] oPart,
   output logic            oDone
);

   localparam int CMAX = (SLEN > PLAT) ? SLEN : PLAT;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
   localparam logic [CW-1:0]   RUN_LAST    = CW'(SLEN - 1);
   localparam logic [CW-1:0]   SETTLE_LAST = (PLAT > 0) ? CW'(PLAT - 1) : CW'(0);
   localparam logic [PWID-1:0] PART_ONE    = PWID'(1);
   localparam logic [PWID-1:0] PART_LAST   = PWID'(FOLD - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CLEAR  = 3'd2,
      RUN    = 3'd3,
      SETTLE = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PWID-1:0] part_q, part_d;
   logic            sel_q, sel_d;
   logic            part_end_s;

   // State, counter, part index and buffer select registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         part_q  <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         sel_q   <= sel_d;
      end
   end

   // Next-state logic; a part ends on the last RUN cycle when there is no
   // settle latency, otherwise on the last SETTLE cycle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      part_d     = part_q;
      sel_d      = sel_q;
      part_end_s = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            sel_d = (state_q == DONE) ? ~sel_q : sel_q;
            if (iStart) begin
               state_d = iLoadW ? LOAD : CLEAR;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            state_d = CLEAR;
         end
         CLEAR: begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            if (cnt_q == RUN_LAST) begin
               cnt_d      = '0;
               state_d    = (PLAT > 0) ? SETTLE : RUN;
               part_end_s = (PLAT == 0);
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d      = '0;
               part_end_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (part_end_s) begin
         if (part_q == PART_LAST) begin
            state_d = DONE;
         end else begin
            state_d = RUN;
            part_d  = part_q + PART_ONE;
         end
      end else begin
         part_d = (state_d == CLEAR) ? '0 : part_d;
      end
   end

   assign oBusy  = (state_q != IDLE);
   assign oLoad  = (state_q == LOAD);
   assign oClear = (state_q == CLEAR);
   assign oDone  = (state_q == DONE);
   assign oSel   = sel_q;
   assign oPart  = part_q;

endmodule

// File: tb/tb_hub_linear_fold_ctrl.sv
// Scoreboard bench: DUT A (FOLD=2, SLEN=4, PLAT=1) and DUT B (FOLD=1, SLEN=4, PLAT=0).
module tb_hub_linear_fold_ctrl;

   typedef struct packed {
      logic [6:0] exp;   // {busy, load, clear, sel, done, part[1:0]}
      logic       st;    // iStart for the edge after this sample
      logic       lw;    // iLoadW for the edge after this sample
   } ent_t;

   logic clk, rst;
   logic a_start, a_loadw, a_busy, a_load, a_clear, a_sel, a_done;
   logic b_start, b_loadw, b_busy, b_load, b_clear, b_sel, b_done;
   logic [0:0] a_part, b_part;

   ent_t       sbq[$];
   ent_t       ent;
   logic [6:0] obs;
   int         n_chk, n_fail, step, done_cnt, done_at;
   logic       exp_sel;
   logic [1:0] exp_part;

   hub_linear_fold_ctrl #(.FOLD(2), .SLEN(4), .PLAT(1)) dut_a (
      .clk(clk), .rst(rst), .iStart(a_start), .iLoadW(a_loadw),
      .oBusy(a_busy), .oLoad(a_load), .oClear(a_clear), .oSel(a_sel),
      .oPart(a_part), .oDone(a_done));

   hub_linear_fold_ctrl #(.FOLD(1), .SLEN(4), .PLAT(0)) dut_b (
      .clk(clk), .rst(rst), .iStart(b_start), .iLoadW(b_loadw),
      .oBusy(b_busy), .oLoad(b_load), .oClear(b_clear), .oSel(b_sel),
      .oPart(b_part), .oDone(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] pack_a();
      return {a_busy, a_load, a_clear, a_sel, a_done, 1'b0, a_part};
   endfunction

   function automatic logic [6:0] pack_b();
      return {b_busy, b_load, b_clear, b_sel, b_done, 1'b0, b_part};
   endfunction

   // Reference model: expected per-cycle outputs of one frame
   task automatic push_frame(input logic load, input logic sel, input logic [1:0] prev_part,
                             input int fold, input int slen, input int plat);
      ent_t e;
      e.st = 1'b0;
      e.lw = 1'b0;
      if (load) begin
         e.exp = {1'b1, 1'b1, 1'b0, sel, 1'b0, prev_part};
         sbq.push_back(e);
      end
      e.exp = {1'b1, 1'b0, 1'b1, sel, 1'b0, 2'd0};
      sbq.push_back(e);
      for (int p = 0; p < fold; p++) begin
         for (int k = 0; k < slen + plat; k++) begin
            e.exp = {1'b1, 1'b0, 1'b0, sel, 1'b0, 2'(p)};
            sbq.push_back(e);
         end
      end
      e.exp = {1'b1, 1'b0, 1'b0, sel, 1'b1, 2'(fold - 1)};
      sbq.push_back(e);
   endtask

   task automatic push_idle(input logic sel, input logic [1:0] part, input int n);
      ent_t e;
      e.st  = 1'b0;
      e.lw  = 1'b0;
      e.exp = {1'b0, 1'b0, 1'b0, sel, 1'b0, part};
      for (int i = 0; i < n; i++) sbq.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      n_chk++;
      if (pack_a() !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_a: got %b expected %b", pack_a(), 7'd0);
      end
      n_chk++;
      if (pack_b() !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_b: got %b expected %b", pack_b(), 7'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_idle(1'b0, 2'd0, 3);
      step = 1;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL reset_idle step %0d: got %b expected %b", step, obs, ent.exp);
         end
         @(posedge clk);
         #1;
         step++;
      end
   endtask

   task automatic test_load_frame();
      push_frame(1'b1, exp_sel, exp_part, 2, 4, 1);
      push_idle(~exp_sel, 2'd1, 2);
      a_start = 1'b1;
      a_loadw = 1'b1;
      @(posedge clk);
      #1;
      step = 1;
      done_cnt = 0;
      done_at = 0;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL load_frame step %0d: got %b expected %b", step, obs, ent.exp);
         end
         if (obs[2]) begin
            done_cnt++;
            done_at = step;
         end
         a_start = ent.st;
         a_loadw = ent.lw;
         @(posedge clk);
         #1;
         step++;
      end
      n_chk++;
      if (done_at !== 13) begin
         n_fail++;
         $display("FAIL load_frame_done_cycle: got %0d expected 13", done_at);
      end
      exp_sel = ~exp_sel;
      exp_part = 2'd1;
   endtask

   task automatic test_noload_frame();
      push_frame(1'b0, exp_sel, exp_part, 2, 4, 1);
      push_idle(~exp_sel, 2'd1, 2);
      a_start = 1'b1;
      a_loadw = 1'b0;
      @(posedge clk);
      #1;
      step = 1;
      done_at = 0;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL noload_frame step %0d: got %b expected %b", step, obs, ent.exp);
         end
         if (obs[2]) done_at = step;
         a_start = ent.st;
         a_loadw = ent.lw;
         @(posedge clk);
         #1;
         step++;
      end
      n_chk++;
      if (done_at !== 12) begin
         n_fail++;
         $display("FAIL noload_done_cycle: got %0d expected 12", done_at);
      end
      exp_sel = ~exp_sel;
   endtask

   task automatic test_back_to_back();
      int n1;
      push_frame(1'b0, exp_sel, exp_part, 2, 4, 1);
      n1 = sbq.size();
      push_frame(1'b0, ~exp_sel, 2'd1, 2, 4, 1);
      for (int i = 0; i < sbq.size() - 1; i++) sbq[i].st = 1'b1;
      push_idle(exp_sel, 2'd1, 2);
      a_start = 1'b1;
      a_loadw = 1'b0;
      @(posedge clk);
      #1;
      step = 1;
      done_cnt = 0;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b expected %b", step, obs, ent.exp);
         end
         if (obs[2]) done_cnt++;
         a_start = ent.st;
         a_loadw = ent.lw;
         @(posedge clk);
         #1;
         step++;
      end
      n_chk++;
      if (done_cnt !== 2 || n1 !== 12) begin
         n_fail++;
         $display("FAIL back_to_back_dones: got %0d expected 2", done_cnt);
      end
   endtask

   task automatic test_ignore_start();
      push_frame(1'b0, exp_sel, exp_part, 2, 4, 1);
      sbq[2].st = 1'b1;
      sbq[5].st = 1'b1;
      sbq[6].st = 1'b1;
      sbq[6].lw = 1'b1;
      sbq[9].st = 1'b1;
      push_idle(~exp_sel, 2'd1, 3);
      a_start = 1'b1;
      a_loadw = 1'b0;
      @(posedge clk);
      #1;
      step = 1;
      done_cnt = 0;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL ignore_start step %0d: got %b expected %b", step, obs, ent.exp);
         end
         if (obs[2]) done_cnt++;
         a_start = ent.st;
         a_loadw = ent.lw;
         @(posedge clk);
         #1;
         step++;
      end
      n_chk++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL ignore_start_dones: got %0d expected 1", done_cnt);
      end
      exp_sel = ~exp_sel;
   endtask

   task automatic test_reset_mid();
      push_frame(1'b1, exp_sel, exp_part, 2, 4, 1);
      a_start = 1'b1;
      a_loadw = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 6; i++) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL reset_mid_pre step %0d: got %b expected %b", i, obs, ent.exp);
         end
         a_start = ent.st;
         a_loadw = ent.lw;
         if (i < 6) begin
            @(posedge clk);
            #1;
         end
      end
      sbq.delete();
      #1;
      rst = 1'b1;
      #1;
      n_chk++;
      if (pack_a() !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b expected %b", pack_a(), 7'd0);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_sel = 1'b0;
      exp_part = 2'd0;
      push_idle(1'b0, 2'd0, 3);
      push_frame(1'b0, 1'b0, 2'd0, 2, 4, 1);
      sbq[2].st = 1'b1;
      push_idle(1'b1, 2'd1, 1);
      step = 1;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_a();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL reset_mid_post step %0d: got %b expected %b", step, obs, ent.exp);
         end
         a_start = ent.st;
         a_loadw = ent.lw;
         @(posedge clk);
         #1;
         step++;
      end
      exp_sel = 1'b1;
      exp_part = 2'd1;
   endtask

   task automatic test_fold1();
      push_frame(1'b0, b_sel, 2'd0, 1, 4, 0);
      push_idle(~b_sel, 2'd0, 2);
      b_start = 1'b1;
      b_loadw = 1'b0;
      @(posedge clk);
      #1;
      step = 1;
      done_at = 0;
      while (sbq.size() > 0) begin
         ent = sbq.pop_front();
         obs = pack_b();
         n_chk++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL fold1 step %0d: got %b expected %b", step, obs, ent.exp);
         end
         if (obs[2]) done_at = step;
         b_start = ent.st;
         b_loadw = ent.lw;
         @(posedge clk);
         #1;
         step++;
      end
      n_chk++;
      if (done_at !== 6) begin
         n_fail++;
         $display("FAIL fold1_done_cycle: got %0d expected 6", done_at);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      exp_sel = 1'b0;
      exp_part = 2'd0;
      a_start = 1'b0;
      a_loadw = 1'b0;
      b_start = 1'b0;
      b_loadw = 1'b0;
      test_reset();
      test_load_frame();
      test_noload_frame();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_fold1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hub_linear_fold_ctrl.md
HUB_LINEAR_FOLD_CTRL -- requirements
Module: HUBLinearFoldCtrl

Interface
REQ-001 SHALL have parameter FOLD, default 1, the number of weight partitions sequenced per frame (FOLD >= 1).
REQ-002 SHALL have parameter PWID, default ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD), the width of the part index.
REQ-003 SHALL have parameter SLEN, default 1024, the bitstream cycles per part (SLEN >= 2).
REQ-004 SHALL have parameter PLAT, default 0, the adder-tree pipeline latency cycles inserted after each part (PLAT >= 0).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port iStart, input, 1 bit: frame request, sampled only in IDLE or DONE.
REQ-008 SHALL have port iLoadW, input, 1 bit: reload weights for this frame, sampled with iStart.
REQ-009 SHALL have port oBusy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port oLoad, output, 1 bit: weight buffer load strobe.
REQ-011 SHALL have port oClear, output, 1 bit: accumulator clear strobe.
REQ-012 SHALL have port oSel, output, 1 bit: double-buffer accumulate-side select.
REQ-013 SHALL have port oPart, output, PWID bits: active weight partition.
REQ-014 SHALL have port oDone, output, 1 bit: single-cycle frame-complete pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD, CLEAR, RUN, SETTLE, DONE.
REQ-016 SHALL generate all outputs as Moore outputs decoded from registered state.
REQ-017 SHALL transition IDLE->LOAD when iStart=1 and iLoadW=1, IDLE->CLEAR when iStart=1 and iLoadW=0, and otherwise remain in IDLE.
REQ-018 SHALL assert oLoad for exactly the single LOAD cycle, then enter CLEAR.
REQ-019 SHALL assert oClear for exactly the single CLEAR cycle, with oPart=0 and the cycle counter=0, then enter RUN.
REQ-020 SHALL, in RUN, increment the cycle counter every cycle; at count SLEN-1 it resets the counter to 0 and enters SETTLE if PLAT>0, else applies REQ-022.
REQ-021 SHALL, in SETTLE, hold oPart and count PLAT cycles, then apply REQ-022.
REQ-022 SHALL, at part end, go to DONE if oPart==FOLD-1, else increment oPart and return to RUN.
REQ-023 SHALL make each part occupy exactly SLEN+PLAT cycles, and each frame 1+FOLD*(SLEN+PLAT)+1 cycles from CLEAR through DONE (plus 1 if LOAD).
REQ-024 SHALL, in DONE, pulse oDone for 1 cycle and toggle oSel on exiting DONE.
REQ-025 SHALL exit DONE per the REQ-017 rules on iStart/iLoadW (back-to-back frames), else go to IDLE.
REQ-026 SHALL ignore iStart in LOAD, CLEAR, RUN and SETTLE, with no queuing.
REQ-027 SHALL size the counter to $clog2(max(SLEN,PLAT)+1) bits with no wrap inside a part.
REQ-028 SHALL hold oPart=0 when FOLD=1 and never increment it.
REQ-029 SHALL hold oPart at its last value in DONE and IDLE.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-frame, immediately force IDLE, counter=0, oPart=0, oSel=0, and oLoad=oClear=oDone=oBusy=0.
REQ-031 SHALL resume in IDLE on the first clock edge after rst falls and require a new iStart.

Verification (FOLD=2, SLEN=4, PLAT=1; cycle 0 = first edge with iStart=1)
REQ-032 SHALL cover: iStart=1, iLoadW=1 -> LOAD c1, CLEAR c2, part0 c3-7, part1 c8-12, oDone c13, oSel 0->1 at c14.
REQ-033 SHALL cover: iStart=1, iLoadW=0 -> no oLoad, CLEAR c1, oDone c12.
REQ-034 SHALL cover: iStart held high -> second CLEAR immediately after DONE, oSel toggling per frame, no LOAD.
REQ-035 SHALL cover: iStart pulses during RUN -> no effect, oDone count=1.
REQ-036 SHALL cover: rst pulse at c6 -> outputs zeroed asynchronously, IDLE, oSel=0.
REQ-037 SHALL cover: FOLD=1, PLAT=0 -> oPart stays 0, oDone SLEN+2 cycles after start without load.
